// File: rtl/mseq_pkg.sv
// mseq_pkg: shared definitions for the m-sequence generator bank.
// Holds the control FSM encoding, reference tap masks and the per-channel
// seed derivation (segment MSBs XOR channel index, all-zero forced to 1).
package mseq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWarm,
    StRun
  } mseq_state_e;

  // Primitive tap masks (bit k set: state[k] feeds back).
  localparam logic [3:0]  PolyW4  = 4'hC;
  localparam logic [15:0] PolyW16 = 16'hD008;
  localparam logic [31:0] PolyW32 = 32'h8020_0003;

  // msbs holds the top width bits of the segment, zero-extended.
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  function automatic logic [31:0] mseq_seed(input logic [31:0] msbs,
                                            input logic [31:0] idx,
                                            input int unsigned width);
    logic [31:0] mask;
    logic [31:0] s;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    s    = (msbs ^ idx) & mask;
    if (s == '0) begin
      s = 32'd1;
    end
    return s;
  endfunction

endpackage

// File: rtl/mseq_lfsr_core.sv
// mseq_lfsr_core: one Fibonacci LFSR channel.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (state resets to 1)
//   load_i        load seed_i (wins over adv_i)
//   adv_i         shift one step using tap mask poly_i
//   seed_i        seed value
//   poly_i        tap mask, bit k set means state[k] feeds back
//   out_o         current output bit (state MSB)
module mseq_lfsr_core #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [Width-1:0] seed_i,
  input  logic [Width-1:0] poly_i,
  output logic             out_o
);

  logic [Width-1:0] state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= {{(Width-1){1'b0}}, 1'b1};
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (adv_i) begin
      state_q <= {state_q[Width-2:0], ^(state_q & poly_i)};
    end
  end

  assign out_o = state_q[Width-1];

endmodule

// File: rtl/mseq_chaos_bank.sv
// mseq_chaos_bank: bank of MSEQ_CH m-sequence LFSRs seeded from one wide word.
// Ports:
//   MSEQ_clk, MSEQ_rst    clock, asynchronous active-high reset
//   MSEQ_din/_vld/_rdy    seed word handshake; channel i uses segment i
//   MSEQ_poly             tap mask latched on accept (0 selects DEFAULT_POLY)
//   MSEQ_en               advance enable; low freezes everything but accept
//   MSEQ_dout/_vld        one registered bit per channel per RUN advance
//   MSEQ_wrap             one-cycle pulse when the step count wraps
//   MSEQ_busy             high while discarding warm-up advances
module mseq_chaos_bank
  import mseq_pkg::*;
#(
  parameter int unsigned MSEQ_CH      = 16,
  parameter int unsigned SEG_W        = 16,
  parameter int unsigned LFSR_W       = 16,
  parameter int unsigned WARMUP       = 64,
  parameter logic [31:0] DEFAULT_POLY = 32'h0000_D008
) (
  input  logic                     MSEQ_clk,
  input  logic                     MSEQ_rst,
  input  logic [MSEQ_CH*SEG_W-1:0] MSEQ_din,
  input  logic                     MSEQ_din_vld,
  output logic                     MSEQ_din_rdy,
  input  logic [LFSR_W-1:0]        MSEQ_poly,
  input  logic                     MSEQ_en,
  output logic [MSEQ_CH-1:0]       MSEQ_dout,
  output logic                     MSEQ_dout_vld,
  output logic                     MSEQ_wrap,
  output logic                     MSEQ_busy
);

  localparam logic [LFSR_W-1:0] DefPoly  = DEFAULT_POLY[LFSR_W-1:0];
  // Last count before wrap: 2^LFSR_W - 2, so the wrap lands on 2^LFSR_W - 1 advances.
  localparam logic [LFSR_W-1:0] StepLast = {{(LFSR_W-1){1'b1}}, 1'b0};
  localparam bit                NoWarm   = (WARMUP == 0);
  localparam logic [9:0]        WarmLast = NoWarm ? 10'd0 : 10'(WARMUP - 1);

  mseq_state_e         state_q;
  logic                rdy_q;
  logic                busy_q;
  logic [MSEQ_CH-1:0]  dout_q;
  logic                vld_q;
  logic                wrap_q;
  logic [LFSR_W-1:0]   poly_q;
  logic [9:0]          warm_q;
  logic [LFSR_W-1:0]   step_q;

  logic                accept;
  logic                advance;
  logic                step_hit;
  logic [LFSR_W-1:0]   step_nxt;
  logic [MSEQ_CH-1:0]  lfsr_out;
  logic                unused_din;

  // Only the top LFSR_W bits of each segment seed a channel.
  assign unused_din = ^MSEQ_din;

  always_comb begin
    accept   = MSEQ_din_vld & rdy_q;
    // Reseed takes priority: no advance in an accept cycle.
    advance  = MSEQ_en & ~accept & (state_q != StIdle);
    step_hit = (step_q == StepLast);
    step_nxt = step_hit ? '0 : step_q + 1'b1;
  end

  for (genvar i = 0; i < MSEQ_CH; i++) begin : g_ch
    logic [31:0] msbs;
    logic [31:0] seed_full;
    logic        unused_seed_hi;

    always_comb begin
      msbs = '0;
      msbs[LFSR_W-1:0] = MSEQ_din[i*SEG_W+SEG_W-1 -: LFSR_W];
    end

    assign seed_full      = mseq_seed(msbs, 32'(i), LFSR_W);
    assign unused_seed_hi = ^(seed_full >> LFSR_W);

    mseq_lfsr_core #(
      .Width (LFSR_W)
    ) u_core (
      .clk_i  (MSEQ_clk),
      .rst_i  (MSEQ_rst),
      .load_i (accept),
      .adv_i  (advance),
      .seed_i (seed_full[LFSR_W-1:0]),
      .poly_i (poly_q),
      .out_o  (lfsr_out[i])
    );
  end

  always_ff @(posedge MSEQ_clk or posedge MSEQ_rst) begin
    if (MSEQ_rst) begin
      state_q <= StIdle;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      poly_q  <= DefPoly;
      warm_q  <= '0;
      step_q  <= '0;
    end else begin
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
      if (state_q == StIdle) begin
        rdy_q <= 1'b1;
      end
      if (accept) begin
        poly_q <= (MSEQ_poly == '0) ? DefPoly : MSEQ_poly;
        warm_q <= '0;
        step_q <= '0;
        if (NoWarm) begin
          state_q <= StRun;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end else begin
          state_q <= StWarm;
          busy_q  <= 1'b1;
          rdy_q   <= 1'b0;
        end
      end else if (MSEQ_en) begin
        unique case (state_q)
          StIdle: ;
          StWarm: begin
            warm_q <= warm_q + 1'b1;
            step_q <= step_nxt;
            wrap_q <= step_hit;
            if (warm_q == WarmLast) begin
              state_q <= StRun;
              busy_q  <= 1'b0;
              rdy_q   <= 1'b1;
            end
          end
          StRun: begin
            step_q <= step_nxt;
            wrap_q <= step_hit;
            dout_q <= lfsr_out;
            vld_q  <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign MSEQ_din_rdy  = rdy_q;
  assign MSEQ_busy     = busy_q;
  assign MSEQ_dout     = dout_q;
  assign MSEQ_dout_vld = vld_q;
  assign MSEQ_wrap     = wrap_q;

endmodule

// File: tb/tb_mseq_chaos_bank.sv
// Bench for mseq_chaos_bank: two configurations (A: 2ch W4 no warm-up,
// B: 4ch W16 warm-up 3) against a behavioural reference model.
module tb_mseq_chaos_bank;

  localparam int P_CH  [2] = '{2, 4};
  localparam int P_SEG [2] = '{8, 16};
  localparam int P_W   [2] = '{4, 16};
  localparam int P_WU  [2] = '{0, 3};
  localparam logic [31:0] P_DEF [2] = '{32'hC, 32'hD008};

  localparam int ModeIdle = 0;
  localparam int ModeWarm = 1;
  localparam int ModeRun  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] din_a;
  logic [63:0] din_b;
  logic [3:0]  poly_a;
  logic [15:0] poly_b;
  logic        vld [2];
  logic        en  [2];

  logic [1:0]  a_dout;
  logic [3:0]  b_dout;
  logic        a_rdy, a_vld, a_wrap, a_busy;
  logic        b_rdy, b_vld, b_wrap, b_busy;
  logic [7:0]  act [2];

  assign act[0] = {2'b00, a_dout, a_vld, a_wrap, a_busy, a_rdy};
  assign act[1] = {b_dout, b_vld, b_wrap, b_busy, b_rdy};

  mseq_chaos_bank #(
    .MSEQ_CH      (2),
    .SEG_W        (8),
    .LFSR_W       (4),
    .WARMUP       (0),
    .DEFAULT_POLY (32'hC)
  ) dut_a (
    .MSEQ_clk      (clk),
    .MSEQ_rst      (rst),
    .MSEQ_din      (din_a),
    .MSEQ_din_vld  (vld[0]),
    .MSEQ_din_rdy  (a_rdy),
    .MSEQ_poly     (poly_a),
    .MSEQ_en       (en[0]),
    .MSEQ_dout     (a_dout),
    .MSEQ_dout_vld (a_vld),
    .MSEQ_wrap     (a_wrap),
    .MSEQ_busy     (a_busy)
  );

  mseq_chaos_bank #(
    .MSEQ_CH      (4),
    .SEG_W        (16),
    .LFSR_W       (16),
    .WARMUP       (3),
    .DEFAULT_POLY (32'hD008)
  ) dut_b (
    .MSEQ_clk      (clk),
    .MSEQ_rst      (rst),
    .MSEQ_din      (din_b),
    .MSEQ_din_vld  (vld[1]),
    .MSEQ_din_rdy  (b_rdy),
    .MSEQ_poly     (poly_b),
    .MSEQ_en       (en[1]),
    .MSEQ_dout     (b_dout),
    .MSEQ_dout_vld (b_vld),
    .MSEQ_wrap     (b_wrap),
    .MSEQ_busy     (b_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, one set per configuration.
  logic [31:0] m_st [2][4];
  int          m_mode  [2];
  int          m_warm  [2];
  int          m_steps [2];
  logic [31:0] m_poly  [2];
  logic [3:0]  m_dout  [2];
  logic        m_vld [2], m_wrap [2], m_busy [2], m_rdy [2];

  function automatic logic [7:0] expv(int d);
    return {m_dout[d], m_vld[d], m_wrap[d], m_busy[d], m_rdy[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) m_st[d][c] = 32'd1;
      m_mode[d] = ModeIdle; m_warm[d] = 0; m_steps[d] = 0;
      m_poly[d] = P_DEF[d]; m_dout[d] = '0;
      m_vld[d] = 0; m_wrap[d] = 0; m_busy[d] = 0; m_rdy[d] = 0;
    end
  endtask

  // One clock edge of the behavioural model, using the inputs seen at that edge.
  task automatic model_update(int d);
    int          w;
    logic [31:0] mask, msbs, s, pin;
    logic [63:0] din;
    logic [3:0]  outs;
    w    = P_W[d];
    mask = (32'd1 << w) - 32'd1;
    din  = (d == 0) ? {48'd0, din_a} : din_b;
    pin  = (d == 0) ? {28'd0, poly_a} : {16'd0, poly_b};
    outs = '0;
    m_vld[d]  = 0;
    m_wrap[d] = 0;
    if (vld[d] && m_rdy[d]) begin
      for (int c = 0; c < P_CH[d]; c++) begin
        msbs = 32'((din >> (c * P_SEG[d] + P_SEG[d] - w))) & mask;
        s = (msbs ^ 32'(c)) & mask;
        m_st[d][c] = (s == 0) ? 32'd1 : s;
      end
      m_poly[d]  = (pin == 0) ? P_DEF[d] : pin;
      m_steps[d] = 0;
      m_warm[d]  = P_WU[d];
      m_mode[d]  = (P_WU[d] == 0) ? ModeRun : ModeWarm;
    end else if (en[d] && m_mode[d] != ModeIdle) begin
      for (int c = 0; c < P_CH[d]; c++) begin
        outs[c] = m_st[d][c][w-1];
        m_st[d][c] = ((m_st[d][c] << 1) |
                      32'($countones(m_st[d][c] & m_poly[d]) % 2)) & mask;
      end
      m_steps[d] = (m_steps[d] + 1) % ((1 << w) - 1);
      if (m_steps[d] == 0) m_wrap[d] = 1;
      if (m_mode[d] == ModeWarm) begin
        m_warm[d] = m_warm[d] - 1;
        if (m_warm[d] == 0) m_mode[d] = ModeRun;
      end else begin
        m_dout[d] = outs;
        m_vld[d]  = 1;
      end
    end
    m_rdy[d]  = (m_mode[d] != ModeWarm);
    m_busy[d] = (m_mode[d] == ModeWarm);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_update(0);
      model_update(1);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act[0] !== expv(0)) begin
      errors++; $display("FAIL reset_a got %h want %h", act[0], expv(0));
    end
    checks++;
    if (act[1] !== 8'h00) begin
      errors++; $display("FAIL reset_b got %h want 00", act[1]);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (a_rdy !== 1'b0) begin
      errors++; $display("FAIL rdy_before_edge got %b want 0", a_rdy);
    end
    tick();
    checks++;
    if ({a_rdy, b_rdy} !== 2'b11) begin
      errors++; $display("FAIL rdy_after_release got %b want 11", {a_rdy, b_rdy});
    end
  endtask

  task automatic test_seed_a();
    poly_a = 4'hC; din_a = 16'h00A0; vld[0] = 1; en[0] = 1;
    tick();
    vld[0] = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if (act[0] !== expv(0)) begin
        errors++; $display("FAIL seed_a_step%0d got %h want %h", k, act[0], expv(0));
      end
      if (k == 0 || k == 15) begin
        checks++;
        if ({a_vld, a_dout} !== 3'b101) begin
          errors++; $display("FAIL seed_a_first%0d got %b want 101", k, {a_vld, a_dout});
        end
      end
      if (k == 1) begin
        checks++;
        if ({a_vld, a_dout} !== 3'b100) begin
          errors++; $display("FAIL seed_a_second got %b want 100", {a_vld, a_dout});
        end
      end
      if (k == 14 || k == 15) begin
        checks++;
        if (a_wrap !== (k == 14)) begin
          errors++; $display("FAIL seed_a_wrap%0d got %b want %b", k, a_wrap, k == 14);
        end
      end
    end
  endtask

  task automatic test_zero_seed_a();
    din_a = 16'h1000; vld[0] = 1; en[0] = 1;
    tick();
    vld[0] = 0;
    checks++;
    if (a_vld !== 1'b0) begin
      errors++; $display("FAIL zero_seed_accept_vld got %b want 0", a_vld);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if (act[0] !== expv(0) || a_dout[0] !== a_dout[1]) begin
        errors++; $display("FAIL zero_seed_step%0d got %h want %h", k, act[0], expv(0));
      end
    end
  endtask

  task automatic test_warmup_b();
    int busy_cnt;
    int first_vld;
    logic pat [5] = '{1, 0, 1, 1, 1};
    busy_cnt = 0; first_vld = -1;
    poly_b = 16'hD008; din_b = {$urandom, $urandom}; vld[1] = 1; en[1] = 1;
    tick();
    vld[1] = 0;
    checks++;
    if ({b_busy, b_rdy, b_vld} !== 3'b100) begin
      errors++; $display("FAIL warm_enter got %b want 100", {b_busy, b_rdy, b_vld});
    end
    if (b_busy === 1'b1) busy_cnt++;
    for (int k = 0; k < 5; k++) begin
      en[1] = pat[k];
      tick();
      checks++;
      if (act[1] !== expv(1)) begin
        errors++; $display("FAIL warm_step%0d got %h want %h", k, act[1], expv(1));
      end
      if (b_busy === 1'b1) busy_cnt++;
      if (b_vld === 1'b1 && first_vld < 0) first_vld = k;
    end
    checks++;
    if (busy_cnt != 4 || first_vld != 4) begin
      errors++; $display("FAIL warm_timing got busy=%0d vld_at=%0d want busy=4 vld_at=4",
                         busy_cnt, first_vld);
    end
  endtask

  task automatic test_reseed_b();
    en[1] = 1;
    for (int k = 0; k < 3; k++) tick();
    din_b = {$urandom, $urandom}; vld[1] = 1;
    tick();
    checks++;
    if ({b_vld, b_busy, b_rdy} !== 3'b010 || act[1] !== expv(1)) begin
      errors++; $display("FAIL reseed_accept got %h want %h", act[1], expv(1));
    end
    din_b = {$urandom, $urandom};
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (b_rdy !== 1'b0 || act[1] !== expv(1)) begin
        errors++; $display("FAIL reseed_holdoff%0d got %h want %h", k, act[1], expv(1));
      end
    end
    vld[1] = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (act[1] !== expv(1)) begin
        errors++; $display("FAIL reseed_run%0d got %h want %h", k, act[1], expv(1));
      end
    end
  endtask

  task automatic test_wrap_b();
    int bad;
    int wrap_at;
    bad = 0; wrap_at = -1;
    poly_b = 16'h0; din_b = {$urandom, $urandom}; vld[1] = 1; en[1] = 1;
    tick();
    vld[1] = 0;
    for (int n = 1; n <= 70000; n++) begin
      tick();
      if (act[1] !== expv(1)) bad++;
      if (b_wrap === 1'b1) begin
        wrap_at = n;
        break;
      end
    end
    checks++;
    if (wrap_at != 65535) begin
      errors++; $display("FAIL wrap_count got %0d want 65535", wrap_at);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wrap_stream got %0d bad cycles want 0", bad);
    end
    tick();
    checks++;
    if (b_wrap !== 1'b0 || act[1] !== expv(1)) begin
      errors++; $display("FAIL wrap_pulse got %h want %h", act[1], expv(1));
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      din_a  = 16'($urandom);
      din_b  = {$urandom, $urandom};
      poly_a = 4'($urandom);
      poly_b = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      for (int d = 0; d < 2; d++) begin
        vld[d] = ($urandom_range(0, 5) == 0);
        en[d]  = ($urandom_range(0, 3) != 0);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (act[d] !== expv(d)) begin
          errors++; $display("FAIL random_%0d_cyc%0d got %h want %h", d, k, act[d], expv(d));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    vld[0] = 1; vld[1] = 1; en[0] = 1; en[1] = 1;
    tick();
    vld[0] = 0; vld[1] = 0;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if ({a_vld, b_vld} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_run got %b want 11", {a_vld, b_vld});
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act[0] !== 8'h00 || act[1] !== 8'h00) begin
      errors++; $display("FAIL mid_reset got %h %h want 00 00", act[0], act[1]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if ({a_rdy, b_rdy} !== 2'b11 || act[1] !== expv(1)) begin
      errors++; $display("FAIL post_reset_rdy got %h want %h", act[1], expv(1));
    end
  endtask

  initial begin
    din_a = '0; din_b = '0; poly_a = '0; poly_b = '0;
    vld[0] = 0; vld[1] = 0; en[0] = 0; en[1] = 0;
    model_reset();
    #2;
    test_reset();
    test_seed_a();
    test_zero_seed_a();
    test_warmup_b();
    test_reseed_b();
    test_wrap_b();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
